// File: rtl/fastinput_gate_ctrl.sv
// Gate-time sequencer for four fast-input pulse counters: times a counting gate,
// snapshots the counts at gate end and streams them out channel by channel.
module fastinput_gate_ctrl #(
    parameter int CNT_W  = 32,
    parameter int GATE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [CNT_W-1:0]  channel0,
    input  logic [CNT_W-1:0]  channel1,
    input  logic [CNT_W-1:0]  channel2,
    input  logic [CNT_W-1:0]  channel3,
    output logic              cnt_clr,
    output logic [CNT_W-1:0]  out_data,
    output logic [1:0]        out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    input  logic              ovr_clr,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GATE, SNAP} state_t;

    state_t            state_q;
    logic [GATE_W-1:0] timer_q;
    logic              cnt_clr_q;
    logic              full_q;
    logic [1:0]        idx_q;
    logic [CNT_W-1:0]  out_data_q;
    logic              frame_done_q;
    logic              overrun_q;
    logic [CNT_W-1:0]  buf_q [4];

    logic              xfer;
    logic              last_xfer;
    logic              buf_free;
    logic              snap_take;
    logic              snap_drop;
    logic [GATE_W-1:0] timer_d;
    logic [1:0]        idx_d;

    assign xfer      = full_q & out_ready;
    assign last_xfer = xfer && (idx_q == 2'd3);
    // The buffer may be refilled in the same cycle its final word leaves.
    assign buf_free  = !full_q || last_xfer;
    assign snap_take = (state_q == SNAP) && buf_free;
    assign snap_drop = (state_q == SNAP) && !buf_free;
    assign timer_d   = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
    assign idx_d     = idx_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cnt_clr_q    <= 1'b0;
            full_q       <= 1'b0;
            idx_q        <= 2'd0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_clr_q    <= 1'b0;
            frame_done_q <= last_xfer;

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q   <= GATE;
                        timer_q   <= timer_d;
                        cnt_clr_q <= 1'b1;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (timer_q == '0) begin
                        state_q <= SNAP;
                    end else begin
                        timer_q <= timer_q - GATE_W'(1);
                    end
                end
                SNAP: begin
                    if (enable) begin
                        state_q   <= GATE;
                        timer_q   <= timer_d;
                        cnt_clr_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A fresh snapshot takes priority over the drain of the old frame.
            if (snap_take) begin
                full_q     <= 1'b1;
                idx_q      <= 2'd0;
                out_data_q <= channel0;
            end else if (last_xfer) begin
                full_q     <= 1'b0;
                idx_q      <= 2'd0;
                out_data_q <= '0;
            end else if (xfer) begin
                idx_q      <= idx_d;
                out_data_q <= buf_q[idx_d];
            end

            if (snap_drop) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (snap_take) begin
            buf_q[0] <= channel0;
            buf_q[1] <= channel1;
            buf_q[2] <= channel2;
            buf_q[3] <= channel3;
        end
    end

    assign cnt_clr    = cnt_clr_q;
    assign out_data   = out_data_q;
    assign out_ch     = idx_q;
    assign out_valid  = full_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE) || full_q;

endmodule

// File: tb/tb_fastinput_gate_ctrl.sv
// Bench for fastinput_gate_ctrl: directed phases with randomized data/handshake,
// checked every cycle against a queue-based model of gate timing and readout.
module tb_fastinput_gate_ctrl;

    localparam int CNT_W  = 32;
    localparam int GATE_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [GATE_W-1:0] gate_len;
    logic [CNT_W-1:0]  channel0, channel1, channel2, channel3;
    logic              cnt_clr;
    logic [CNT_W-1:0]  out_data;
    logic [1:0]        out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;
    logic              ovr_clr;
    logic              overrun;
    logic              busy;

    always #5 clk = ~clk;

    fastinput_gate_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .gate_len(gate_len),
        .channel0(channel0), .channel1(channel1), .channel2(channel2), .channel3(channel3),
        .cnt_clr(cnt_clr), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .ovr_clr(ovr_clr),
        .overrun(overrun), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: mode 0=idle, 1=gating, 2=snapshot; m_left counts gate
    // cycles still to run; the frame buffer is a queue of {channel, count} words.
    int           m_mode = 0;
    int           m_left = 0;
    logic [33:0]  m_q[$];
    logic         m_clr = 1'b0;
    logic         m_fd  = 1'b0;
    logic         m_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic xfer, last, drop;
        int   len;
        if (rst) begin
            m_mode = 0; m_left = 0; m_q.delete();
            m_clr = 1'b0; m_fd = 1'b0; m_ovr = 1'b0;
        end else begin
            xfer = (m_q.size() > 0) && out_ready;
            last = 1'b0;
            drop = 1'b0;
            if (xfer) begin
                last = (m_q[0][33:32] == 2'd3);
                void'(m_q.pop_front());
            end
            m_clr = 1'b0;
            m_fd  = last;
            len   = (gate_len == 0) ? 1 : int'(gate_len);
            case (m_mode)
                0: if (enable) begin m_mode = 1; m_left = len; m_clr = 1'b1; end
                1: begin
                    if (!enable)          m_mode = 0;
                    else if (m_left == 1) m_mode = 2;
                    else                  m_left = m_left - 1;
                end
                default: begin
                    if (m_q.size() == 0) begin
                        m_q.push_back({2'd0, channel0});
                        m_q.push_back({2'd1, channel1});
                        m_q.push_back({2'd2, channel2});
                        m_q.push_back({2'd3, channel3});
                    end else begin
                        drop = 1'b1;
                    end
                    if (enable) begin m_mode = 1; m_left = len; m_clr = 1'b1; end
                    else m_mode = 0;
                end
            endcase
            if (drop)         m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
        end
    endtask

    task automatic step();
        logic        v;
        logic [1:0]  ch;
        logic [31:0] d;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        v  = (m_q.size() > 0);
        ch = v ? m_q[0][33:32] : 2'd0;
        d  = v ? m_q[0][31:0]  : 32'd0;
        check("cnt_clr",    32'(cnt_clr),    32'(m_clr));
        check("out_valid",  32'(out_valid),  32'(v));
        check("out_ch",     32'(out_ch),     32'(ch));
        check("out_data",   out_data,        d);
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("busy",       32'(busy),       32'((m_mode != 0) || v));
    endtask

    task automatic rand_ch();
        channel0 = $urandom; channel1 = $urandom;
        channel2 = $urandom; channel3 = $urandom;
    endtask

    initial begin
        bit found;
        rst = 1'b1; enable = 1'b0; gate_len = '0; out_ready = 1'b0; ovr_clr = 1'b0;
        channel0 = '0; channel1 = '0; channel2 = '0; channel3 = '0;
        step(); step();
        rst = 1'b0;

        // Basic frame with fixed counts including the all-ones boundary value
        enable = 1'b1; gate_len = 24'd10; out_ready = 1'b1;
        channel0 = 32'd5; channel1 = 32'd7; channel2 = 32'd0; channel3 = 32'hFFFF_FFFF;
        for (int i = 0; i < 30; i++) step();

        // Backpressure: ready toggling, counts changing every cycle
        for (int i = 0; i < 40; i++) begin
            out_ready = i[0];
            rand_ch();
            step();
        end

        // Overrun: consumer stalled, short gates
        gate_len = 24'd2; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin rand_ch(); step(); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin rand_ch(); step(); end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();

        // Drain/snap coincidence: one stall per 5-cycle frame period
        gate_len = 24'd4;
        for (int i = 0; i < 40; i++) begin
            out_ready = ((cyc % 5) != 0);
            rand_ch();
            step();
        end

        // Abort mid-gate, then let the pending frame drain
        out_ready = 1'b1; gate_len = 24'd20;
        for (int i = 0; i < 8; i++) begin rand_ch(); step(); end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // gate_len = 0 gives single-cycle gates
        enable = 1'b1; gate_len = '0;
        for (int i = 0; i < 30; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rand_ch();
            step();
        end

        // Reset while the readout sits at channel 2
        gate_len = 24'd3; out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            out_ready = ($urandom_range(0, 1) != 0);
            rand_ch();
            step();
            if (m_q.size() > 0 && m_q[0][33:32] == 2'd2) found = 1'b1;
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL reset_setup observed=no_idx2 expected=idx2_within_100_cycles");
        end
        rst = 1'b1; step();
        rst = 1'b0; enable = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Random soak
        for (int i = 0; i < 300; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            gate_len  = GATE_W'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 3) != 0);
            ovr_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            rand_ch();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
